// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: shared op-class codes, state encoding and widths for the memory stage.
package mem_stage_ctrl_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ALU = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_BR  = 3'b100;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: counts REQ cycles without ack and flags when the timeout limit is reached.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 8'd1;
    end
    // cnt_q counts completed wait cycles, so the current REQ cycle is number cnt_q+1
    assign hit_o = (cnt_q == LIMIT);
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory stage driving a req/ack data port and the registered write-back signals.
// Optional request timeout with sticky err_o is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [REG_W-1:0]  rsd_i,
    input  logic [2:0]        Op_i,
    input  logic              valid_i,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              all_stall_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [REG_W-1:0]  wb_rsd_o,
    output logic              wb_we_o,
    output logic              err_o
);
    state_e            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, wb_we_q, wb_we_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic [REG_W-1:0]  wb_rsd_q, wb_rsd_d;
    logic              timeout;
    logic              in_req, is_mem, is_alu;
    assign in_req = (state_q == REQ);
    assign is_mem = valid_i && (Op_i == OP_LW || Op_i == OP_SW);
    assign is_alu = valid_i && (Op_i == OP_ALU);
`ifdef MEM_TIMEOUT_EN
    logic err_q;
    mem_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (!in_req && state_d == REQ),
        .en_i  (in_req && !mem_ack_i),
        .hit_o (timeout)
    );
    always_ff @(posedge clk_i) begin
        if (!rst_i) err_q <= 1'b0;
        else if (in_req && !mem_ack_i && timeout) err_q <= 1'b1;
    end
    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif
    // DONE issues exactly like IDLE, so back-to-back memory ops need no bubble
    always_comb begin
        state_d   = IDLE;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        wb_rsd_d  = wb_rsd_q;
        wb_we_d   = 1'b0;
        if (in_req) begin
            state_d = REQ;
            if (mem_ack_i) begin
                state_d = DONE;
                req_d   = 1'b0;
                if (!we_q) begin
                    wb_data_d = mem_rdata_i;
                    wb_rsd_d  = rsd_i;
                    wb_we_d   = (rsd_i != '0);
                end
            end else if (timeout) begin
                state_d = DONE;
                req_d   = 1'b0;
            end
        end else if (is_alu) begin
            wb_data_d = alu_result_i;
            wb_rsd_d  = rsd_i;
            wb_we_d   = (rsd_i != '0);
        end else if (is_mem) begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = (Op_i == OP_SW);
            addr_d  = alu_result_i;
            wdata_d = rs2_data_i;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            wb_rsd_q  <= '0;
            wb_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
            wb_rsd_q  <= wb_rsd_d;
            wb_we_q   <= wb_we_d;
        end
    end
    assign all_stall_o = rst_i && ((!in_req && is_mem) || (in_req && !mem_ack_i && !timeout));
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign wb_data_o   = wb_data_q;
    assign wb_rsd_o    = wb_rsd_q;
    assign wb_we_o     = wb_we_q;
endmodule
